// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the sign-magnitude datapath blocks
// (adder, format converters, future multiplier).
package fxp_pkg;

  // Default word width of the sign-magnitude datapath
  localparam int FXP_WIDTH     = 16;
  // Widest word the helpers below can inspect
  localparam int FXP_MAX_WIDTH = 64;

  // Index of the sign bit in a sign-magnitude word of the given width
  function automatic int sm_sign_bit(input int width);
    return width - 1;
  endfunction

  // True when a sign-magnitude word (zero-extended to FXP_MAX_WIDTH) is -0
  function automatic logic sm_negz(input logic [FXP_MAX_WIDTH-1:0] word,
                                   input int                       width);
    logic [FXP_MAX_WIDTH-1:0] mag_mask;
    logic                     sign;
    mag_mask = (64'd1 << sm_sign_bit(width)) - 64'd1;
    sign     = ((word >> sm_sign_bit(width)) & 64'd1) != 64'd0;
    return sign && ((word & mag_mask) == 64'd0);
  endfunction

endpackage

// File: rtl/fxp_pipe_stage.sv
// One-entry valid/ready register slice. The slot refills in the same cycle
// its word leaves, so a chain of slices sustains one word per cycle.
module fxp_pipe_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic          load_s;

  // Next state: load when the slot is empty or its word is taken this cycle
  always_comb begin
    load_s = !valid_q || out_ready;
    if (load_s) begin
      valid_d = in_valid;
    end else begin
      valid_d = valid_q;
    end
    if (load_s && in_valid) begin
      data_d = in_data;
    end else begin
      data_d = data_q;
    end
  end

  // Slot registers; data is cleared too so outputs read zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {DW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = load_s;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/sm_to_tc_stream.sv
// Streaming sign-magnitude to two's-complement converter: two register
// slices with the conversion between them, negative zero canonicalised to 0
// and flagged, plus a saturating debug counter of negative-zero inputs.
module sm_to_tc_stream
  import fxp_pkg::*;
#(
  parameter int WIDTH     = FXP_WIDTH,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_negz,
  output logic [CNT_WIDTH-1:0] nz_count,
  input  logic                 clr_count
);

  localparam int SIGN_BIT = sm_sign_bit(WIDTH);
  localparam logic [OUT_WIDTH-1:0] ONE_OW  = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  if (OUT_WIDTH < WIDTH) begin : g_out_width_check
    $error("sm_to_tc_stream: OUT_WIDTH must be >= WIDTH");
  end

  logic [1:0]           rst_sync_q;
  logic [1:0]           rst_sync_d;
  logic                 rst_int_n;

  logic                 in_negz_s;
  logic                 s1_in_valid_s;
  logic                 s1_in_ready_s;
  logic [WIDTH:0]       s1_in_data_s;
  logic                 s1_valid_s;
  logic [WIDTH:0]       s1_data_s;
  logic                 s2_in_ready_s;

  logic                 s1_sign_s;
  logic [WIDTH-2:0]     s1_mag_s;
  logic                 s1_negz_s;
  logic [OUT_WIDTH-1:0] mag_ext_s;
  logic [OUT_WIDTH-1:0] tc_s;
  logic [OUT_WIDTH:0]   s2_in_data_s;
  logic [OUT_WIDTH:0]   s2_data_s;

  logic                 accept_s;
  logic [CNT_WIDTH-1:0] nz_count_q;
  logic [CNT_WIDTH-1:0] nz_count_d;

  // Reset synchroniser: asserts immediately, releases two edges later
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Input side: flag negative zero before it enters the pipeline
  always_comb begin
    in_negz_s     = sm_negz(FXP_MAX_WIDTH'(in_data), WIDTH);
    s1_in_valid_s = in_valid && rst_int_n;
    s1_in_data_s  = {in_negz_s, in_data};
    in_ready      = s1_in_ready_s && rst_int_n;
    accept_s      = in_valid && in_ready;
  end

  fxp_pipe_stage #(.DW(WIDTH + 1)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .in_valid  (s1_in_valid_s),
    .in_ready  (s1_in_ready_s),
    .in_data   (s1_in_data_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_in_ready_s),
    .out_data  (s1_data_s)
  );

  // Conversion: negate the zero-extended magnitude for negative words;
  // -0 naturally becomes 0 because ~0 + 1 wraps to 0
  always_comb begin
    s1_negz_s = s1_data_s[WIDTH];
    s1_sign_s = s1_data_s[SIGN_BIT];
    s1_mag_s  = s1_data_s[SIGN_BIT-1:0];
    mag_ext_s = OUT_WIDTH'(s1_mag_s);
    if (s1_sign_s) begin
      tc_s = ~mag_ext_s + ONE_OW;
    end else begin
      tc_s = mag_ext_s;
    end
    s2_in_data_s = {s1_negz_s, tc_s};
  end

  fxp_pipe_stage #(.DW(OUT_WIDTH + 1)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_in_ready_s),
    .in_data   (s2_in_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data_s)
  );

  assign out_data = s2_data_s[OUT_WIDTH-1:0];
  assign out_negz = s2_data_s[OUT_WIDTH];

  // Debug counter: clear wins over increment, increment saturates
  always_comb begin
    if (clr_count) begin
      nz_count_d = {CNT_WIDTH{1'b0}};
    end else if (accept_s && in_negz_s && (nz_count_q != CNT_MAX)) begin
      nz_count_d = nz_count_q + ONE_CNT;
    end else begin
      nz_count_d = nz_count_q;
    end
  end

  // Debug counter register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      nz_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      nz_count_q <= nz_count_d;
    end
  end

  assign nz_count = nz_count_q;

endmodule

// File: tb/tb_sm_to_tc_stream.sv
// Bench for sm_to_tc_stream: directed vectors, a randomised stream against
// an integer-arithmetic reference model, counter and reset scenarios.
module tb_sm_to_tc_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_negz, clr_count;
  logic [15:0] in_data, out_data, nz_count;

  logic        in_valid24, in_ready24, out_valid24, out_ready24, out_negz24, clr24;
  logic [15:0] in_data24;
  logic [23:0] out_data24;
  logic [2:0]  nz_count24;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sm_to_tc_stream #(.WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_negz(out_negz), .nz_count(nz_count),
    .clr_count(clr_count)
  );

  sm_to_tc_stream #(.WIDTH(16), .OUT_WIDTH(24), .CNT_WIDTH(3)) dut24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid24), .in_ready(in_ready24),
    .in_data(in_data24), .out_valid(out_valid24), .out_ready(out_ready24),
    .out_data(out_data24), .out_negz(out_negz24), .nz_count(nz_count24),
    .clr_count(clr24)
  );

  // Reference: signed integer value of a sign-magnitude word, as 24 bits
  function automatic logic [23:0] ref_tc(input logic [15:0] w);
    int v;
    v = int'(w[14:0]);
    if (w[15]) v = -v;
    return 24'(v);
  endfunction

  task automatic send_check(input logic [15:0] d, input logic [15:0] exp,
                            input logic exp_nz, input string nm);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_early: out_valid %b expected 0", nm, out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp || out_negz !== exp_nz) begin
      tests_failed++;
      $display("FAIL %s: got v=%b d=%h nz=%b expected v=1 d=%h nz=%b", nm, out_valid, out_data, out_negz, exp, exp_nz);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_check24(input logic [15:0] d, input logic [23:0] exp, input string nm);
    in_valid24 = 1'b1; in_data24 = d; out_ready24 = 1'b1;
    @(posedge clk); #1;
    in_valid24 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (out_valid24 !== 1'b1 || out_data24 !== exp) begin
      tests_failed++;
      $display("FAIL %s: got v=%b d=%h expected v=1 d=%h", nm, out_valid24, out_data24, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_negz !== 1'b0 || nz_count !== 16'h0000 || out_valid24 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b d=%h nz=%b cnt=%h v24=%b expected all zero", out_valid, out_data, out_negz, nz_count, out_valid24);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_convert;
    send_check(16'h0005, 16'h0005, 1'b0, "pos5");
    send_check(16'h8005, 16'hFFFB, 1'b0, "neg5");
    send_check(16'hFFFF, 16'h8001, 1'b0, "negmax");
    send_check(16'h7FFF, 16'h7FFF, 1'b0, "posmax");
    send_check(16'h0000, 16'h0000, 1'b0, "poszero");
  endtask

  task automatic test_negz;
    @(negedge clk);
    tests_run++;
    if (nz_count !== 16'd0) begin tests_failed++; $display("FAIL nz_start: got %0d expected 0", nz_count); end
    @(posedge clk); #1;
    send_check(16'h8000, 16'h0000, 1'b1, "negz");
    tests_run++;
    if (nz_count !== 16'd1) begin tests_failed++; $display("FAIL nz_inc: got %0d expected 1", nz_count); end
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk);
    tests_run++;
    if (nz_count !== 16'd0) begin tests_failed++; $display("FAIL nz_clr: got %0d expected 0", nz_count); end
    @(posedge clk); #1;
    // clear and a negative-zero accept in the same cycle: clear wins
    clr_count = 1'b1; in_valid = 1'b1; in_data = 16'h8000; out_ready = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (nz_count !== 16'd0) begin tests_failed++; $display("FAIL nz_clr_prio: got %0d expected 0", nz_count); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wide;
    send_check24(16'h8001, 24'hFFFFFF, "w_neg1");
    send_check24(16'h7FFF, 24'h007FFF, "w_posmax");
    send_check24(16'hFFFF, 24'hFF8001, "w_negmax");
    // saturation of the 3-bit counter
    in_valid24 = 1'b1; in_data24 = 16'h8000; out_ready24 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (nz_count24 !== 3'((k < 7) ? k : 7)) begin
        tests_failed++;
        $display("FAIL nz_sat_%0d: got %0d expected %0d", k, nz_count24, (k < 7) ? k : 7);
      end
    end
    in_valid24 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid24 !== 1'b1 || out_data24 !== 24'h000000 || out_negz24 !== 1'b1) begin
      tests_failed++;
      $display("FAIL w_negz: got v=%b d=%h nz=%b expected 1/000000/1", out_valid24, out_data24, out_negz24);
    end
    @(posedge clk); #1;
    clr24 = 1'b1;
    @(posedge clk); #1;
    clr24 = 1'b0;
    tests_run++;
    if (nz_count24 !== 3'd0) begin tests_failed++; $display("FAIL w_clr: got %0d expected 0", nz_count24); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] w[10];
    logic [23:0] t;
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 10);
      in_data  = (c < 10) ? w[c] : 16'($urandom);
      @(negedge clk);
      if (c < 10) begin
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_%0d: got %b expected 1", c, in_ready); end
      end
      tests_run++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_fill_%0d: out_valid %b expected 0", c, out_valid); end
      end else begin
        t = ref_tc(w[c-2]);
        if (out_valid !== 1'b1 || out_data !== t[15:0]) begin
          tests_failed++;
          $display("FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", c, out_valid, out_data, t[15:0]);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stream;
    logic [15:0] exp_q[$];
    logic [15:0] w, held, e;
    logic [23:0] t;
    logic        exp_rdy;
    bit          stalled = 1'b0;
    int          idx = 1, received = 0, cyc = 0;
    held = 16'h0000;
    while (received < 100 && cyc < 3000) begin
      w         = {1'($urandom_range(0, 1)), 15'(idx)};
      in_valid  = (idx <= 100) && ($urandom_range(0, 3) != 0);
      in_data   = in_valid ? w : 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = !(exp_q.size() == 2 && !out_ready);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL stream_in_ready: got %b expected %b (in flight %0d)", in_ready, exp_rdy, exp_q.size());
      end
      if (stalled) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          tests_failed++;
          $display("FAIL stream_stall: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_spurious: got d=%h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          received++;
          if (out_data !== e || out_negz !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_data_%0d: got %h nz=%b expected %h nz=0", received, out_data, out_negz, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        t = ref_tc(in_data);
        exp_q.push_back(t[15:0]);
        idx++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (received != 100) begin
      tests_failed++;
      $display("FAIL stream_timeout: got %0d words expected 100", received);
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h8000;
    @(posedge clk); #1;
    in_data = 16'h0003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || nz_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL mid_setup: got v=%b rdy=%b cnt=%0d expected 1/0/1", out_valid, in_ready, nz_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || nz_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_async: got v=%b cnt=%0d expected 0/0", out_valid, nz_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_stale_%0d: out_valid %b expected 0", c, out_valid); end
      @(posedge clk); #1;
    end
    send_check(16'h0042, 16'h0042, 1'b0, "post_rst");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0; clr_count = 1'b0;
    in_valid24 = 1'b0; in_data24 = 16'h0000; out_ready24 = 1'b1; clr24 = 1'b0;
    test_reset();
    test_convert();
    test_negz();
    test_wide();
    test_back_to_back();
    test_stream();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
